// File: rtl/reg_file_seq.sv
// Debug save/restore sequencer for the 3-port MIPS register file.
// DUMP streams FIRST_REG..LAST_REG out over valid/ready; LOAD writes incoming words back in order.
module reg_file_seq #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] A1,
  input  logic [DATA_W-1:0] RD1,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              WE3,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_SEND,
    S_LOAD,
    S_FIN
  } state_t;

  localparam logic [ADDR_W-1:0] L_FIRST = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(LAST_REG);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_out_data;
  logic [ADDR_W-1:0]   r_out_addr;

  logic w_active;
  logic w_last;
  logic w_send;
  logic w_load;

  assign w_active = (r_state != S_IDLE);
  assign w_last   = (r_addr == L_LAST);
  assign w_send   = (r_state == S_SEND);
  assign w_load   = (r_state == S_LOAD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_addr     <= L_FIRST;
      r_out_data <= '0;
      r_out_addr <= '0;
    end else if (w_active && abort) begin
      // abort outranks any handshake presented in the same cycle
      r_state <= S_IDLE;
      r_addr  <= L_FIRST;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= mode ? S_LOAD : S_RD;
            r_addr  <= L_FIRST;
          end
        end
        S_RD: begin
          r_out_data <= RD1;
          r_out_addr <= r_addr;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            if (w_last) begin
              r_state <= S_FIN;
            end else begin
              r_addr  <= r_addr + 1'b1;
              r_state <= S_RD;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (w_last) r_state <= S_FIN;
            else        r_addr  <= r_addr + 1'b1;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_addr  <= L_FIRST;
        end
        default: begin
          r_state <= S_IDLE;
          r_addr  <= L_FIRST;
        end
      endcase
    end
  end

  assign busy      = w_active;
  assign done      = (r_state == S_FIN);
  assign A1        = w_active ? r_addr : '0;
  assign A3        = w_active ? r_addr : '0;
  assign in_ready  = w_load;
  assign WD3       = w_load ? in_data : '0;
  // write fires on the handshake edge itself, so the word is never written twice
  assign WE3       = w_load & in_valid & ~abort;
  assign out_valid = w_send & ~abort;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;

endmodule

// File: tb/tb_reg_file_seq.sv
// Directed bench for reg_file_seq: full-range instance plus a 4..6 window instance,
// both driving a small behavioural register file where writes to r0 are dropped.
module tb_reg_file_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mode, abort;
  logic        busy, done;
  logic [4:0]  A1, A3;
  logic [31:0] RD1, WD3;
  logic        WE3;
  logic [31:0] out_data;
  logic [4:0]  out_addr;
  logic        out_valid, out_ready;
  logic [31:0] in_data;
  logic        in_valid, in_ready;

  logic        b_start, b_mode, b_abort, b_busy, b_done;
  logic [4:0]  b_A1, b_A3, b_out_addr;
  logic [31:0] b_RD1, b_WD3, b_out_data, b_in_data;
  logic        b_WE3, b_out_valid, b_out_ready, b_in_valid, b_in_ready;

  logic [31:0] rf     [32];
  logic [31:0] exp_rf [32];
  logic        pl_go;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file_seq u_dut (
    .clk(clk), .reset(rst_n), .start(start), .mode(mode), .abort(abort),
    .busy(busy), .done(done), .A1(A1), .RD1(RD1), .A3(A3), .WD3(WD3), .WE3(WE3),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
  );

  reg_file_seq #(.FIRST_REG(4), .LAST_REG(6)) u_win (
    .clk(clk), .reset(rst_n), .start(b_start), .mode(b_mode), .abort(b_abort),
    .busy(b_busy), .done(b_done), .A1(b_A1), .RD1(b_RD1), .A3(b_A3), .WD3(b_WD3), .WE3(b_WE3),
    .out_data(b_out_data), .out_addr(b_out_addr), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready)
  );

  assign RD1   = rf[A1];
  assign b_RD1 = rf[b_A1];

  always @(posedge clk) begin
    if (pl_go) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'(100 + i);
    end else if (WE3 && A3 != 5'd0) begin
      rf[A3] <= WD3;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_a1"},    32'(A1), 32'd0);
    chk({tag, "_a3"},    32'(A3), 32'd0);
    chk({tag, "_wd3"},   WD3, 32'd0);
    chk({tag, "_we3"},   32'(WE3), 32'd0);
    chk({tag, "_ovld"},  32'(out_valid), 32'd0);
    chk({tag, "_odat"},  out_data, 32'd0);
    chk({tag, "_oadr"},  32'(out_addr), 32'd0);
    chk({tag, "_irdy"},  32'(in_ready), 32'd0);
  endtask

  // Entered and left at posedge+1.
  task automatic run_dump(input bit toggle);
    int n = 0;
    int cyc = 0;
    bit have_held = 0;
    logic [31:0] held_d = '0;
    out_ready = 1'b1;
    mode  = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (n < 32 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (have_held) chk("dump_hold", out_data, held_d);
        if (out_ready) begin
          chk("dump_addr", 32'(out_addr), 32'(n));
          chk("dump_data", out_data, exp_rf[n]);
          n++;
          have_held = 0;
        end else begin
          have_held = 1;
          held_d = out_data;
        end
      end
      @(posedge clk); #1;
      if (toggle) out_ready = ~out_ready;
    end
    chk("dump_words", 32'(n), 32'd32);
    if (!toggle) chk("dump_cycles", 32'(cyc), 32'd64);
    out_ready = 1'b1;
    @(negedge clk);
    chk("dump_done", 32'(done), 32'd1);
    chk("dump_fin_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("dump_done_off", 32'(done), 32'd0);
    chk("dump_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  // abort_at < 0: gapped stream to completion; otherwise continuous stream aborted at that word.
  task automatic run_load(input logic [31:0] base, input int abort_at);
    int n = 0;
    int cyc = 0;
    bit aborted = 0;
    mode  = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (n < 32 && cyc < 200 && !aborted) begin
      in_data  = base + 32'(n);
      in_valid = (abort_at >= 0) ? 1'b1 : (cyc % 3 != 2);
      abort    = (abort_at >= 0 && n == abort_at);
      @(negedge clk);
      chk("ld_rdy", 32'(in_ready), 32'd1);
      chk("ld_a3", 32'(A3), 32'(n));
      chk("ld_we", 32'(WE3), 32'(in_valid && !abort));
      if (abort) begin
        chk("ab_ovld", 32'(out_valid), 32'd0);
        aborted = 1;
      end else if (in_valid) begin
        chk("ld_wd3", WD3, in_data);
        n++;
      end
      cyc++;
      @(posedge clk); #1;
      abort = 1'b0;
    end
    in_valid = 1'b0;
    if (aborted) begin
      @(negedge clk);
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_done", 32'(done), 32'd0);
      @(posedge clk); #1;
    end else begin
      chk("ld_words", 32'(n), 32'd32);
      @(negedge clk);
      chk("ld_done", 32'(done), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ld_idle", 32'(busy), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    int done_cyc;
    int idle_cyc;
    bit found;
    rst_n = 1'b0; pl_go = 1'b1;
    start = 0; mode = 0; abort = 0; out_ready = 1; in_data = '0; in_valid = 0;
    b_start = 0; b_mode = 0; b_abort = 0; b_out_ready = 1; b_in_data = '0; b_in_valid = 0;
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'(100 + i);

    @(negedge clk);
    chk_idle_zero("rst");
    @(posedge clk); #1;
    pl_go = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_dump(1'b0);

    run_dump(1'b1);

    run_load(32'hA0, -1);
    for (int i = 1; i < 32; i++) exp_rf[i] = 32'hA0 + 32'(i);
    chk("ld_r0_kept", rf[0], 32'd100);
    run_dump(1'b1);

    run_load(32'h500, 9);
    chk("ab_r9_kept", rf[9], 32'hA9);
    chk("ab_r8_written", rf[8], 32'h508);
    for (int i = 1; i < 9; i++) exp_rf[i] = 32'h500 + 32'(i);

    // start with abort in IDLE: start must win
    mode = 1'b0; start = 1'b1; abort = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("sa_busy", 32'(busy), 32'd1);
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (out_valid && out_addr == 5'd12) found = 1;
    end
    chk("mr_reach12", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle_zero("mr");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_dump(1'b0);

    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    n = 0; done_cyc = -1; idle_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (b_out_valid && b_out_ready) begin
        chk("win_addr", 32'(b_out_addr), 32'(4 + n));
        chk("win_data", b_out_data, exp_rf[4 + n]);
        n++;
      end
      if (b_done && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0 && !b_busy && idle_cyc < 0) idle_cyc = c;
    end
    chk("win_words", 32'(n), 32'd3);
    chk("win_done_cyc", 32'(done_cyc), 32'd7);
    chk("win_idle_cyc", 32'(idle_cyc), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
